// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: resynchronises h_sync/v_sync/rgb, measures line period,
// sync widths and lines per frame, and reports lock status plus sticky error flags.
module vga_sync_monitor #(
  parameter int CLK_PER_PIX = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int TOL         = 2,
  parameter int SYNC_POL    = 0
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  red,
  input  logic [2:0]  green,
  input  logic [1:0]  blue,
  input  logic        err_clr,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err,
  output logic [15:0] h_period,
  output logic [10:0] v_lines,
  output logic [15:0] frame_cnt
);

  localparam int   H_PERIOD_CLK = H_TOTAL * CLK_PER_PIX;
  localparam int   H_WIDTH_CLK  = H_SYNC * CLK_PER_PIX;
  localparam int   H_TIMEOUT    = 2 * H_PERIOD_CLK;
  localparam logic POL          = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Input resynchronisers; stage 3 is only the previous stage-2 value for edge detection.
  logic       hs_s1_q, hs_s2_q, hs_s3_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0] rgb_s1_q, rgb_s2_q;

  state_e      state_q, state_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [15:0] h_period_q, h_period_d;
  logic [10:0] v_lines_q, v_lines_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        locked_q, locked_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;
  logic        blank_err_q, blank_err_d;

  logic h_assert, h_deassert, v_assert, v_deassert;
  logic armed, h_timeout, h_evt, v_evt, blank_evt;

  function automatic logic out_of_tol(input logic [15:0] cnt, input int target);
    int diff;
    diff = int'(cnt) - target;
    return (diff > TOL) || (diff < -TOL);
  endfunction

  assign h_assert   = (hs_s2_q == POL) && (hs_s3_q != POL);
  assign h_deassert = (hs_s2_q != POL) && (hs_s3_q == POL);
  assign v_assert   = (vs_s2_q == POL) && (vs_s3_q != POL);
  assign v_deassert = (vs_s2_q != POL) && (vs_s3_q == POL);

  // Timing is only judged once a frame start has been seen; the timeout is the exception
  // because a dead h_sync must be reported even before acquisition.
  assign armed     = (state_q != SEARCH);
  assign h_timeout = (h_cnt_q == 16'(H_TIMEOUT));

  assign h_evt = h_timeout
               | (armed & h_assert   & out_of_tol(h_cnt_q, H_PERIOD_CLK))
               | (armed & h_deassert & out_of_tol(h_cnt_q, H_WIDTH_CLK));

  assign v_evt = (armed & v_assert   & (line_cnt_q != 11'(V_TOTAL)))
               | (armed & v_deassert & (line_cnt_q != 11'(V_SYNC)));

  assign blank_evt = (rgb_s2_q != 8'h00) && ((hs_s2_q == POL) || (vs_s2_q == POL));

  // NOTE: every *_d gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    line_cnt_d  = line_cnt_q;
    h_period_d  = h_period_q;
    v_lines_d   = v_lines_q;
    frame_cnt_d = frame_cnt_q;

    if (h_assert) begin
      h_cnt_d    = 16'd1;
      h_period_d = h_cnt_q;
    end else if (h_cnt_q != 16'hFFFF) begin
      h_cnt_d = h_cnt_q + 16'd1;
    end

    // A coincident h edge is the first line of the new frame.
    if (v_assert) begin
      v_lines_d  = line_cnt_q;
      line_cnt_d = h_assert ? 11'd1 : 11'd0;
    end else if (h_assert && (line_cnt_q != 11'h7FF)) begin
      line_cnt_d = line_cnt_q + 11'd1;
    end

    case (state_q)
      SEARCH: begin
        if (!h_evt && v_assert) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (h_evt || v_evt)  state_d = SEARCH;
        else if (v_assert)   state_d = LOCKED;
      end
      LOCKED: begin
        if (h_evt || v_evt) begin
          state_d = SEARCH;
        end else if (v_assert) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);

    // A new error in the same cycle as err_clr keeps the flag set.
    h_err_d     = h_evt     | (h_err_q     & ~err_clr);
    v_err_d     = v_evt     | (v_err_q     & ~err_clr);
    blank_err_d = blank_evt | (blank_err_q & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      hs_s1_q  <= ~POL;
      hs_s2_q  <= ~POL;
      hs_s3_q  <= ~POL;
      vs_s1_q  <= ~POL;
      vs_s2_q  <= ~POL;
      vs_s3_q  <= ~POL;
      rgb_s1_q <= 8'h00;
      rgb_s2_q <= 8'h00;
    end else begin
      hs_s1_q  <= h_sync;
      hs_s2_q  <= hs_s1_q;
      hs_s3_q  <= hs_s2_q;
      vs_s1_q  <= v_sync;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      rgb_s1_q <= {red, green, blue};
      rgb_s2_q <= rgb_s1_q;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= 16'd0;
      line_cnt_q  <= 11'd0;
      h_period_q  <= 16'd0;
      v_lines_q   <= 11'd0;
      frame_cnt_q <= 16'd0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      blank_err_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      line_cnt_q  <= line_cnt_d;
      h_period_q  <= h_period_d;
      v_lines_q   <= v_lines_d;
      frame_cnt_q <= frame_cnt_d;
      locked_q    <= locked_d;
      h_err_q     <= h_err_d;
      v_err_q     <= v_err_d;
      blank_err_q <= blank_err_d;
    end
  end

  assign locked    = locked_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign blank_err = blank_err_q;
  assign h_period  = h_period_q;
  assign v_lines   = v_lines_q;
  assign frame_cnt = frame_cnt_q;

endmodule
